// File: rtl/fetch_queue_gen2.sv
// Instruction-fetch front end: direct-mapped I-cache with burst refill, next-PC
// generation and a circular issue queue. Define FETCH_JALR_STALL_EN to halt fetch after a JALR.
module fetch_queue_gen2 #(
   parameter int          IQ_DEPTH     = 8,
   parameter int          ICACHE_IDX_W = 9,
   parameter int          BURST_LEN    = 4,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        aviliable_from_memcont,
   output logic        enable_to_memcont,
   output logic [31:0] address_to_memcont,
   input  logic        one_inst_finish_from_memcont,
   input  logic        end_from_memcont,
   input  logic [31:0] inst_from_memcont,
   output logic [31:0] pc_to_predictor,
   output logic [31:0] inst_to_predictor,
   input  logic        jump_flag_from_predictor,
   input  logic [31:0] imm_from_predictor,
   input  logic        is_jalr_from_predictor,
   output logic        valid_to_dispatcher,
   output logic [31:0] inst_to_dispatcher,
   output logic [31:0] inst_pos_to_dispatcher,
   output logic        pred_jump_to_dispatcher,
   output logic [31:0] rollback_pos_to_dispatcher,
   input  logic        full_flag_in,
   input  logic        rollback_flag_from_rob,
   input  logic [31:0] target_pc_from_rob,
   input  logic        jalr_commit_from_rob
);
   localparam int QW   = $clog2(IQ_DEPTH);
   localparam int NSET = 1 << ICACHE_IDX_W;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pos;
      logic        pj;
      logic [31:0] rb;
   } iq_ent_t;

   logic [31:0] c_inst [NSET];
   logic [31:0] c_tag  [NSET];
   logic [NSET-1:0] c_vld;

   iq_ent_t iq [IQ_DEPTH];
   logic [QW-1:0] head, tail;
   logic [QW:0]   count;

   logic [31:0] pc;
   logic        busy;
   logic [4:0]  k;
   logic        halt;

   logic [ICACHE_IDX_W-1:0] pc_idx, fill_idx;
   logic [31:0] fill_addr;
   logic        hit, word, fill_we, fill_last, fill_start, do_ins, launch;

   assign pc_idx     = pc[ICACHE_IDX_W+1:2];
   assign hit        = c_vld[pc_idx] && (c_tag[pc_idx] == pc);
   assign fill_addr  = address_to_memcont + {25'd0, k, 2'b00};
   assign fill_idx   = fill_addr[ICACHE_IDX_W+1:2];
   assign word       = one_inst_finish_from_memcont || end_from_memcont;
   assign fill_we    = busy && word;
   assign fill_last  = end_from_memcont || (k == 5'(BURST_LEN - 1));
   assign fill_start = !hit && aviliable_from_memcont && !busy;
   assign do_ins     = hit && (count != (QW+1)'(IQ_DEPTH)) && !halt && !rollback_flag_from_rob;
   assign launch     = (count != '0) && !full_flag_in && !rollback_flag_from_rob;

   assign pc_to_predictor   = pc;
   assign inst_to_predictor = hit ? c_inst[pc_idx] : 32'h0;
   assign enable_to_memcont = busy;

   // Data arrays carry no reset; the valid bits alone gate their use.
   always_ff @(posedge clk_in) begin
      if (rdy_in && fill_we) begin
         c_inst[fill_idx] <= inst_from_memcont;
         c_tag[fill_idx]  <= fill_addr;
      end
      if (rdy_in && do_ins)
         iq[tail] <= '{inst: c_inst[pc_idx], pos: pc, pj: jump_flag_from_predictor, rb: pc + 32'd4};
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pc                         <= RESET_PC;
         head                       <= '0;
         tail                       <= '0;
         count                      <= '0;
         busy                       <= 1'b0;
         k                          <= '0;
         address_to_memcont         <= '0;
         c_vld                      <= '0;
         valid_to_dispatcher        <= 1'b0;
         inst_to_dispatcher         <= '0;
         inst_pos_to_dispatcher     <= '0;
         pred_jump_to_dispatcher    <= 1'b0;
         rollback_pos_to_dispatcher <= '0;
      end else if (rdy_in) begin
         // The refill runs independently of rollback so fetched words are never wasted.
         if (fill_we) begin
            c_vld[fill_idx] <= 1'b1;
            k               <= k + 5'd1;
            if (fill_last) busy <= 1'b0;
         end else if (fill_start) begin
            busy               <= 1'b1;
            address_to_memcont <= pc;
            k                  <= '0;
         end

         valid_to_dispatcher        <= launch;
         inst_to_dispatcher         <= launch ? iq[head].inst : '0;
         inst_pos_to_dispatcher     <= launch ? iq[head].pos  : '0;
         pred_jump_to_dispatcher    <= launch ? iq[head].pj   : 1'b0;
         rollback_pos_to_dispatcher <= launch ? iq[head].rb   : '0;

         if (rollback_flag_from_rob) begin
            pc    <= target_pc_from_rob;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (do_ins) begin
               tail <= tail + 1'b1;
               pc   <= jump_flag_from_predictor ? pc + imm_from_predictor : pc + 32'd4;
            end
            if (launch) head <= head + 1'b1;
            if (do_ins && !launch)      count <= count + 1'b1;
            else if (!do_ins && launch) count <= count - 1'b1;
         end
      end
   end

`ifdef FETCH_JALR_STALL_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)                            halt <= 1'b0;
      else if (rdy_in) begin
         if (rollback_flag_from_rob)         halt <= 1'b0;
         else if (do_ins && is_jalr_from_predictor) halt <= 1'b1;
         else if (jalr_commit_from_rob)      halt <= 1'b0;
      end
   end
`else
   logic unused_jalr;
   assign halt        = 1'b0;
   assign unused_jalr = is_jalr_from_predictor ^ jalr_commit_from_rob;
`endif

endmodule

// File: tb/tb_fetch_queue_gen2.sv
// Randomized bench for fetch_queue_gen2 against a queue/associative-array reference model.
module tb_fetch_queue_gen2;
   localparam int          DEPTH = 8;
   localparam int          IDXW  = 9;
   localparam int          BURST = 4;
   localparam logic [31:0] RPC   = 32'h0;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b0;
   logic        aviliable_from_memcont = 1'b0;
   logic        enable_to_memcont;
   logic [31:0] address_to_memcont;
   logic        one_inst_finish_from_memcont = 1'b0;
   logic        end_from_memcont = 1'b0;
   logic [31:0] inst_from_memcont = '0;
   logic [31:0] pc_to_predictor, inst_to_predictor;
   logic        jump_flag_from_predictor = 1'b0;
   logic [31:0] imm_from_predictor = '0;
   logic        is_jalr_from_predictor = 1'b0;
   logic        valid_to_dispatcher;
   logic [31:0] inst_to_dispatcher, inst_pos_to_dispatcher, rollback_pos_to_dispatcher;
   logic        pred_jump_to_dispatcher;
   logic        full_flag_in = 1'b0;
   logic        rollback_flag_from_rob = 1'b0;
   logic [31:0] target_pc_from_rob = '0;
   logic        jalr_commit_from_rob = 1'b0;

   fetch_queue_gen2 #(.IQ_DEPTH(DEPTH), .ICACHE_IDX_W(IDXW), .BURST_LEN(BURST), .RESET_PC(RPC)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .aviliable_from_memcont(aviliable_from_memcont),
      .enable_to_memcont(enable_to_memcont), .address_to_memcont(address_to_memcont),
      .one_inst_finish_from_memcont(one_inst_finish_from_memcont),
      .end_from_memcont(end_from_memcont), .inst_from_memcont(inst_from_memcont),
      .pc_to_predictor(pc_to_predictor), .inst_to_predictor(inst_to_predictor),
      .jump_flag_from_predictor(jump_flag_from_predictor), .imm_from_predictor(imm_from_predictor),
      .is_jalr_from_predictor(is_jalr_from_predictor),
      .valid_to_dispatcher(valid_to_dispatcher), .inst_to_dispatcher(inst_to_dispatcher),
      .inst_pos_to_dispatcher(inst_pos_to_dispatcher), .pred_jump_to_dispatcher(pred_jump_to_dispatcher),
      .rollback_pos_to_dispatcher(rollback_pos_to_dispatcher), .full_flag_in(full_flag_in),
      .rollback_flag_from_rob(rollback_flag_from_rob), .target_pc_from_rob(target_pc_from_rob),
      .jalr_commit_from_rob(jalr_commit_from_rob)
   );

   always #5 clk_in = ~clk_in;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model state
   typedef struct {logic [31:0] inst, pos, rb; logic pj;} ent_t;
   ent_t        q[$];
   logic [31:0] m_tag  [int];
   logic [31:0] m_inst [int];
   logic [31:0] m_pc, m_base;
   int          m_k;
   bit          m_busy, m_halt;
   ent_t        m_out;
   bit          m_vld;

   int p_rdy = 100, p_full = 0, p_rb = 0, p_avail = 75;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[IDXW+1:2]);
   endfunction

   task automatic mreset();
      q.delete(); m_tag.delete(); m_inst.delete();
      m_pc = RPC; m_base = '0; m_k = 0; m_busy = 0; m_halt = 0; m_vld = 0;
      m_out = '{32'h0, 32'h0, 32'h0, 1'b0};
   endtask

   task automatic check_outputs();
      int  i;
      bit  h;
      i = idx_of(m_pc);
      h = m_tag.exists(i) && m_tag[i] == m_pc;
      chk("pc", pc_to_predictor, m_pc);
      chk("inst_pred", inst_to_predictor, h ? m_inst[i] : 32'h0);
      chk("enable", {31'd0, enable_to_memcont}, {31'd0, m_busy});
      chk("address", address_to_memcont, m_base);
      chk("valid", {31'd0, valid_to_dispatcher}, {31'd0, m_vld});
      chk("inst_out", inst_to_dispatcher, m_out.inst);
      chk("pos_out", inst_pos_to_dispatcher, m_out.pos);
      chk("pj_out", {31'd0, pred_jump_to_dispatcher}, {31'd0, m_out.pj});
      chk("rb_out", rollback_pos_to_dispatcher, m_out.rb);
   endtask

   // Called at negedge: check, drive next inputs, advance the model to the post-edge state.
   task automatic step();
      int          i, fi;
      bit          h, ins, wd;
      logic [31:0] ci, fa;
      check_outputs();

      rdy_in = ($urandom_range(99) < p_rdy);
      aviliable_from_memcont = ($urandom_range(99) < p_avail);
      wd = rdy_in && m_busy && ($urandom_range(99) < 70);
      one_inst_finish_from_memcont = wd;
      end_from_memcont = wd && (m_k == BURST - 1 || $urandom_range(99) < 8);
      inst_from_memcont = wd ? memw(m_base + 32'(4 * m_k)) : $urandom;
      jump_flag_from_predictor = ($urandom_range(99) < 15);
      case ($urandom_range(5))
         0: imm_from_predictor = 32'hFFFF_FFF8;
         1: imm_from_predictor = 32'h8;
         2: imm_from_predictor = 32'h10;
         3: imm_from_predictor = 32'hFFFF_FFC0;
         4: imm_from_predictor = 32'h40;
         default: imm_from_predictor = 32'hFFFF_FFF0;
      endcase
      is_jalr_from_predictor = ($urandom_range(99) < 10);
      full_flag_in = ($urandom_range(99) < p_full);
      rollback_flag_from_rob = ($urandom_range(999) < p_rb);
      target_pc_from_rob = {21'd0, 9'($urandom_range(511)), 2'b00};
      jalr_commit_from_rob = ($urandom_range(99) < 5);

      if (rdy_in) begin
         i  = idx_of(m_pc);
         h  = m_tag.exists(i) && m_tag[i] == m_pc;
         ci = h ? m_inst[i] : 32'h0;
         if (m_busy && wd) begin
            fa = m_base + 32'(4 * m_k);
            fi = idx_of(fa);
            m_tag[fi]  = fa;
            m_inst[fi] = inst_from_memcont;
            if (end_from_memcont || m_k == BURST - 1) m_busy = 0;
            else m_k++;
         end else if (!m_busy && !h && aviliable_from_memcont) begin
            m_busy = 1; m_base = m_pc; m_k = 0;
         end
         m_vld = 0;
         m_out = '{32'h0, 32'h0, 32'h0, 1'b0};
         if (rollback_flag_from_rob) begin
            q.delete();
            m_pc = target_pc_from_rob;
            m_halt = 0;
         end else begin
            ins = h && q.size() < DEPTH && !m_halt;
            if (q.size() != 0 && !full_flag_in) begin
               m_out = q.pop_front();
               m_vld = 1;
            end
            if (ins) begin
               q.push_back('{ci, m_pc, m_pc + 32'd4, jump_flag_from_predictor});
               m_pc = jump_flag_from_predictor ? m_pc + imm_from_predictor : m_pc + 32'd4;
            end
`ifdef FETCH_JALR_STALL_EN
            if (ins && is_jalr_from_predictor) m_halt = 1;
            else if (jalr_commit_from_rob)    m_halt = 0;
`endif
         end
      end
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   initial begin
      mreset();
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      rdy_in = 1'b1;
      // warm-up: cold misses from RESET_PC, no flushes, dispatcher always ready
      p_rdy = 100; p_full = 0; p_rb = 0;
      repeat (80) step();
      // dispatcher stalled: queue fills to capacity and fetch must stop
      p_full = 100;
      repeat (60) step();
      // one-cycle release at a full queue
      p_full = 0;  step();
      p_full = 100; repeat (10) step();
      // mixed traffic with flushes, stalls and frozen cycles
      p_full = 30; p_rb = 30; p_rdy = 90;
      repeat (3000) step();
      // steady-state insert+launch around the wrap point
      p_full = 0; p_rb = 0; p_rdy = 100;
      repeat (200) step();

      // asynchronous reset in the middle of a burst
      p_rb = 0; p_avail = 100;
      begin
         int n = 0;
         rollback_flag_from_rob = 1'b1;
         target_pc_from_rob = 32'h0000_1800;
         while (!m_busy && n < 200) begin
            if (n == 0) p_rb = 1000;
            else p_rb = 0;
            step();
            n++;
         end
         chk("burst_seen", {31'd0, m_busy}, 32'd1);
      end
      one_inst_finish_from_memcont = 1'b0;
      end_from_memcont = 1'b0;
      rst_in = 1'b1;
      #1;
      chk("rst_enable", {31'd0, enable_to_memcont}, 32'd0);
      chk("rst_valid", {31'd0, valid_to_dispatcher}, 32'd0);
      chk("rst_pc", pc_to_predictor, RPC);
      chk("rst_addr", address_to_memcont, 32'h0);
      mreset();
      @(negedge clk_in);
      rst_in = 1'b0;
      p_avail = 75;
      repeat (60) step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", n_chk);
      $fatal(1, "bench timeout");
   end
endmodule
